// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared FSM type and slot constants for serial_word_serializer (macro SERIALIZER_PARITY_EN adds a parity slot)
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

`ifdef SERIALIZER_PARITY_EN
  localparam int PARITY_SLOTS = 1;
`else
  localparam int PARITY_SLOTS = 0;
`endif

endpackage

// File: rtl/serializer_slot_counter.sv
// rtl/serializer_slot_counter.sv - clearable slot up-counter with terminal and pre-terminal count flags
module serializer_slot_counter #(
  parameter int CW   = 3,
  parameter int LAST = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic tc_o,
  output logic pre_tc_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: a clear (new word loaded) takes priority over advancing a slot
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // pre_tc lets the parent register word_done so it lands on the last slot
  assign tc_o     = (count_q == CW'(LAST));
  assign pre_tc_o = (count_q == CW'(LAST - 1));

endmodule

// File: rtl/serial_word_serializer.sv
// rtl/serial_word_serializer.sv - LSB-first word serializer with one-word holding register (SERIALIZER_PARITY_EN appends even parity)
module serial_word_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_input,
  input  logic             input_valid,
  output logic             input_ready,
  output logic             serial_output,
  output logic             serial_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int LAST = WIDTH - 1 + PARITY_SLOTS;
  localparam int CW   = $clog2(WIDTH + PARITY_SLOTS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             serial_output_q, serial_output_d;
  logic             serial_valid_q, serial_valid_d;
  logic             word_done_q, word_done_d;
  logic             load;
  logic             cnt_inc;
  logic             cnt_tc;
  logic             cnt_pre_tc;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  serializer_slot_counter #(
    .CW   (CW),
    .LAST (LAST)
  ) u_slot_counter (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (load),
    .inc_i    (cnt_inc),
    .tc_o     (cnt_tc),
    .pre_tc_o (cnt_pre_tc)
  );

  // Next state: accept into the holding register, move it into the shifter, advance slots
  always_comb begin
    state_d         = state_q;
    hold_data_d     = hold_data_q;
    hold_full_d     = hold_full_q;
    shift_d         = shift_q;
    load            = 1'b0;
    cnt_inc         = 1'b0;
    serial_output_d = 1'b0;
    serial_valid_d  = 1'b0;
    word_done_d     = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d        = parity_q;
`endif

    // Accept only when empty, so it can never coincide with a reload below
    if (input_valid && !hold_full_q) begin
      hold_data_d = parallel_input;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_tc) begin
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shift_d = shift_q >> 1;
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d     = hold_data_q;
      hold_full_d = 1'b0;
      state_d     = SHIFT;
`ifdef SERIALIZER_PARITY_EN
      parity_d    = ^hold_data_q;
`endif
    end

    // Outputs are registered from the slot the shifter is about to occupy
    if (state_d == SHIFT) begin
      serial_valid_d  = 1'b1;
      serial_output_d = shift_d[0];
      word_done_d     = cnt_inc && cnt_pre_tc;
`ifdef SERIALIZER_PARITY_EN
      if (cnt_inc && cnt_pre_tc) begin
        serial_output_d = parity_q;
      end
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      hold_data_q     <= '0;
      hold_full_q     <= 1'b0;
      shift_q         <= '0;
      serial_output_q <= 1'b0;
      serial_valid_q  <= 1'b0;
      word_done_q     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q        <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      hold_data_q     <= hold_data_d;
      hold_full_q     <= hold_full_d;
      shift_q         <= shift_d;
      serial_output_q <= serial_output_d;
      serial_valid_q  <= serial_valid_d;
      word_done_q     <= word_done_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q        <= parity_d;
`endif
    end
  end

  assign input_ready   = !hold_full_q;
  assign busy          = (state_q == SHIFT) || hold_full_q;
  assign serial_output = serial_output_q;
  assign serial_valid  = serial_valid_q;
  assign word_done     = word_done_q;

endmodule

// File: doc/serial_word_serializer.md
# serial_word_serializer

Parallel-to-serial converter that feeds the serial-in/parallel-out shift stage. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register. Each word is emitted on `serial_output`, one bit per clock, LSB first, so the downstream shifter holds the word in natural bit order after WIDTH shifts. `word_done` marks the final slot so the consumer knows when its parallel word is complete.

## Interface
- `WIDTH`, default 8: word width in bits; legal range ≥ 2.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
- `parallel_input`  input  WIDTH  word to serialize; sampled when `input_valid && input_ready`.
- `input_valid`  input  1  upstream has a word.
- `input_ready`  output  1  holding register empty; equals `!hold_full`, with no combinational path from `input_valid`.
- `serial_output`  output  1  current serial bit; 0 when idle.
- `serial_valid`  output  1  `serial_output` carries a data (or parity) bit this cycle.
- `word_done`  output  1  high for exactly one cycle: the last slot of each word.
- `busy`  output  1  shifter active or holding register full.

## Operation
- Storage: holding register (`hold_data`, `hold_full`), shift register, slot counter, and 2-state FSM IDLE / SHIFT.
- Accept: on a clock edge with `input_valid && input_ready`, the edge loads `hold_data` and sets `hold_full`.
- IDLE → SHIFT: when `hold_full`, the next edge moves the hold word into the shifter, clears `hold_full`, and sets counter = 0.
- In SHIFT:
  - `serial_output` = shifter[0]; `serial_valid` = 1.
  - Each edge shifts right by one and increments the counter.
- Last slot (counter = WIDTH−1, or the parity slot when enabled): `word_done` = 1.
  - If `hold_full`, the same edge reloads the shifter from the hold register and stays in SHIFT, giving a gapless stream.
  - Otherwise the FSM returns to IDLE.
- Accept and reload on the same edge cannot collide: `input_ready` is low while `hold_full`, so a new word enters the hold register only after it has emptied.
- Idle outputs: `serial_output` = 0, `serial_valid` = 0, `word_done` = 0.
- All outputs are registered except `input_ready` and `busy`, which are decoded from registered state.

## Timing
- Reset values: `serial_output` 0, `serial_valid` 0, `word_done` 0, `hold_full` 0, FSM IDLE, counter 0. After reset, `input_ready` = 1 and `busy` = 0.
- Latency: a word accepted at edge T puts bit 0 on `serial_output` after edge T+1; bit k appears after edge T+1+k.
- `word_done` is asserted after edge T+WIDTH (T+WIDTH+1 with parity).
- Throughput: one word per WIDTH cycles (WIDTH+1 with parity) while upstream keeps the hold register filled.
- `input_ready` returns high the cycle after a reload, leaving WIDTH−1 cycles to refill the hold register before the next word boundary.
- Reset asserted mid-word: outputs clear asynchronously; the in-flight word and the held word are discarded, with no partial `word_done`. Release is synchronized externally.
- `input_valid` may drop at any time without effect unless a transfer occurred.

## Configuration
- `SERIALIZER_PARITY_EN` defined: each word gets one extra slot after bit WIDTH−1.
  - `serial_output` = even parity (XOR of all WIDTH bits), with `serial_valid` = 1.
  - `word_done` moves from bit WIDTH−1 to this parity slot.
  - Slot period is WIDTH+1.
- Macro undefined: no parity logic; period is WIDTH.

## Structure
- Package `serializer_pkg`: FSM state typedef (IDLE, SHIFT), and constant `PARITY_SLOTS` (1 or 0, selected by the macro).
- Slot-counter width is derived as `$clog2(WIDTH + PARITY_SLOTS)`.
- One natural sub-module: `serializer_slot_counter`, a clearable up-counter with a terminal-count flag that drives the last-slot decision.

## Test plan
- Reset then idle: hold `reset` = 0, release, no `input_valid` → `serial_output` = 0, `serial_valid` = 0, `input_ready` = 1 indefinitely.
- Single word, WIDTH=8: send 0xA5 at edge T → bits 1,0,1,0,0,1,0,1 after edges T+1..T+8; `word_done` only after T+8; FSM returns to IDLE.
- Back-to-back: keep `input_valid` high with 0x01, 0xFF, 0x3C → 24 consecutive valid bits, no gap; `word_done` exactly every 8th cycle; `input_ready` low while the hold register is full.
- Reset mid-word: accept 0xF0, assert `reset` after 3 bits → outputs 0 immediately; after release, 0x0F is serialized cleanly with no residue from 0xF0.
- Parity (`SERIALIZER_PARITY_EN`):
  - Send 0x07 → 8 data bits then parity bit 1 with `word_done` on slot 9.
  - Send 0xA5 → parity bit 0.
